// File: rtl/attn_value_accum_if.sv
// Handshake and bus bundle between softmax, value buffer and the context accumulator.
// The slave side is the accumulator; the master side drives start/probs and serves value rows.
interface attn_value_accum_if #(
    parameter int SEQ_LEN = 3,
    parameter int FRAC_W  = 8,
    parameter int V_W     = 8,
    parameter int DIM     = 4
);
    localparam int ADDR_W = $clog2(SEQ_LEN);

    logic                      start;
    logic [SEQ_LEN*FRAC_W-1:0] probs;
    logic                      v_rd_en;
    logic [ADDR_W-1:0]         v_rd_addr;
    logic [DIM*V_W-1:0]        v_rd_data;
    logic                      busy;
    logic                      done;
    logic [DIM*V_W-1:0]        ctx;

    modport master (
        output start, probs, v_rd_data,
        input  v_rd_en, v_rd_addr, busy, done, ctx
    );

    modport slave (
        input  start, probs, v_rd_data,
        output v_rd_en, v_rd_addr, busy, done, ctx
    );
endinterface

// File: rtl/attn_value_accum.sv
// Attention context accumulator: ctx[d] = round/sat(sum_k p[k]*V[k][d]).
// One lane instance per head-dimension element; a shared sequencer streams value rows.
module attn_value_lane #(
    parameter int V_W    = 8,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 19
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    add_en,
    input  logic                    load,
    input  logic signed [V_W-1:0]   v,
    input  logic [FRAC_W-1:0]       p,
    output logic [V_W-1:0]          ctx
);
    localparam int PROD_W = V_W + FRAC_W + 1;
    localparam int RND_W  = ACC_W + 1;
    localparam logic signed [RND_W-1:0] SAT_HI = RND_W'((2 ** (V_W - 1)) - 1);
    localparam logic signed [RND_W-1:0] SAT_LO = RND_W'(-(2 ** (V_W - 1)));

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  sum;
    logic signed [RND_W-1:0]  rnd;
    logic signed [RND_W-1:0]  r;

    assign prod = PROD_W'(v) * PROD_W'($signed({1'b0, p}));
    assign sum  = acc + (add_en ? ACC_W'(prod) : '0);
    // Round on the post-add sum so the final row lands in the same edge as the output.
    assign rnd  = RND_W'(sum) + RND_W'(2 ** (FRAC_W - 1));
    assign r    = rnd >>> FRAC_W;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            ctx <= '0;
        end else begin
            if (clr)
                acc <= '0;
            else if (add_en)
                acc <= sum;
            if (load) begin
                if (r > SAT_HI)
                    ctx <= SAT_HI[V_W-1:0];
                else if (r < SAT_LO)
                    ctx <= SAT_LO[V_W-1:0];
                else
                    ctx <= r[V_W-1:0];
            end
        end
    end
endmodule

module attn_value_accum #(
    parameter int SEQ_LEN = 3,
    parameter int FRAC_W  = 8,
    parameter int V_W     = 8,
    parameter int DIM     = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    attn_value_accum_if.slave bus
);
    localparam int ADDR_W = $clog2(SEQ_LEN);
    localparam int ACC_W  = V_W + FRAC_W + 1 + $clog2(SEQ_LEN);
    localparam int STAGES = 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SEQ_LEN - 1);

    // OUT is the done cycle; it overlaps IDLE so a new start can be taken there.
    typedef enum logic [1:0] {IDLE, RUN, FLUSH, OUT} state_t;

    state_t state, state_nx;
    logic accept, load_ctx, issue_nx, last_addr;
    logic [STAGES:0] vld_pipe;
    logic [ADDR_W-1:0] rd_addr, acc_cnt;
    logic [SEQ_LEN-1:0][FRAC_W-1:0] p_lat;
    logic done_q;
    logic [DIM-1:0][V_W-1:0] ctx_lane;

    assign last_addr     = (rd_addr == LAST);
    assign bus.v_rd_en   = vld_pipe[0];
    assign bus.v_rd_addr = rd_addr;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.ctx       = ctx_lane;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        load_ctx = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (vld_pipe[0] && last_addr)
                    state_nx = FLUSH;
            end
            FLUSH: begin
                load_ctx = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign issue_nx = accept | (vld_pipe[0] & ~last_addr);

    // vld_pipe[0] is the read strobe; vld_pipe[STAGES] marks returning row data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            rd_addr  <= '0;
            acc_cnt  <= '0;
            p_lat    <= '0;
            done_q   <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], issue_nx};
            done_q   <= load_ctx;
            if (accept) begin
                rd_addr <= '0;
                acc_cnt <= '0;
                p_lat   <= bus.probs;
            end else begin
                if (vld_pipe[0] && !last_addr)
                    rd_addr <= rd_addr + ADDR_W'(1);
                if (vld_pipe[STAGES])
                    acc_cnt <= (acc_cnt == LAST) ? '0 : acc_cnt + ADDR_W'(1);
            end
        end
    end

    for (genvar d = 0; d < DIM; d++) begin : g_lane
        attn_value_lane #(
            .V_W   (V_W),
            .FRAC_W(FRAC_W),
            .ACC_W (ACC_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (accept),
            .add_en(vld_pipe[STAGES]),
            .load  (load_ctx),
            .v     (bus.v_rd_data[d*V_W +: V_W]),
            .p     (p_lat[acc_cnt]),
            .ctx   (ctx_lane[d])
        );
    end
endmodule

// File: tb/tb_attn_value_accum.sv
// Directed + randomized bench for attn_value_accum against a plain-arithmetic reference.
// The value buffer is modelled as a 1-cycle-latency memory returning noise when not read.
module tb_attn_value_accum;
    localparam int SEQ_LEN = 3;
    localparam int FRAC_W  = 8;
    localparam int V_W     = 8;
    localparam int DIM     = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    attn_value_accum_if #(.SEQ_LEN(SEQ_LEN), .FRAC_W(FRAC_W), .V_W(V_W), .DIM(DIM)) bus();

    attn_value_accum #(.SEQ_LEN(SEQ_LEN), .FRAC_W(FRAC_W), .V_W(V_W), .DIM(DIM)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    logic [DIM*V_W-1:0] vmem [SEQ_LEN];

    always @(posedge clk) begin
        if (bus.v_rd_en)
            bus.v_rd_data <= vmem[bus.v_rd_addr];
        else
            bus.v_rd_data <= (DIM*V_W)'({$urandom, $urandom});
    end

    int checks = 0;
    int errors = 0;
    int p_job [SEQ_LEN];
    int v_job [SEQ_LEN][DIM];
    int exp_ctx [DIM];
    bit pending;
    bit ch;
    int ex;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round half up = floor((sum + den/2) / den), then clamp to the signed V_W range.
    function automatic int ref_elem(input int d);
        longint s, num, den, q;
        s = 0;
        for (int k = 0; k < SEQ_LEN; k++)
            s += longint'(v_job[k][d]) * longint'(p_job[k]);
        den = longint'(1) << FRAC_W;
        num = s + den / 2;
        q = num / den;
        if (num < 0 && (num % den) != 0)
            q = q - 1;
        if (q > 127)  q = 127;
        if (q < -128) q = -128;
        return int'(q);
    endfunction

    task automatic set_job();
        for (int k = 0; k < SEQ_LEN; k++) begin
            bus.probs[k*FRAC_W +: FRAC_W] = FRAC_W'(p_job[k]);
            for (int d = 0; d < DIM; d++)
                vmem[k][d*V_W +: V_W] = V_W'(v_job[k][d]);
        end
        for (int d = 0; d < DIM; d++)
            exp_ctx[d] = ref_elem(d);
    endtask

    task automatic rand_job();
        for (int k = 0; k < SEQ_LEN; k++) begin
            p_job[k] = int'($urandom_range(255));
            for (int d = 0; d < DIM; d++)
                v_job[k][d] = int'($urandom_range(255)) - 128;
        end
    endtask

    task automatic fill_job(input int p0, input int p1, input int p2, input int vall);
        p_job[0] = p0; p_job[1] = p1; p_job[2] = p2;
        for (int k = 0; k < SEQ_LEN; k++)
            for (int d = 0; d < DIM; d++)
                v_job[k][d] = vall;
    endtask

    // Called at #1 after an edge with start already raised; follows cycles T+1..T+SEQ_LEN+2.
    task automatic track(input string tag, input int extra, input bit chain);
        logic signed [V_W-1:0] cv;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int c = 1; c <= SEQ_LEN + 2; c++) begin
            if (c > 1) begin
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
            check($sformatf("%s/en c%0d", tag, c), bus.v_rd_en, (c <= SEQ_LEN));
            if (c <= SEQ_LEN)
                check($sformatf("%s/addr c%0d", tag, c), bus.v_rd_addr, c - 1);
            check($sformatf("%s/busy c%0d", tag, c), bus.busy, (c <= SEQ_LEN + 1));
            check($sformatf("%s/done c%0d", tag, c), bus.done, (c == SEQ_LEN + 2));
            if (c == SEQ_LEN + 2) begin
                for (int d = 0; d < DIM; d++) begin
                    cv = bus.ctx[d*V_W +: V_W];
                    check($sformatf("%s/ctx%0d", tag, d), cv, exp_ctx[d]);
                end
            end
            if (c == extra) begin
                bus.start = 1'b1;
                bus.probs = (SEQ_LEN*FRAC_W)'($urandom);
            end
            if (c == SEQ_LEN + 2 && chain) begin
                rand_job();
                set_job();
                bus.start = 1'b1;
            end
        end
    endtask

    initial begin
        logic signed [V_W-1:0] cv;
        int lit [DIM];
        bus.start = 1'b0;
        bus.probs = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst/en", bus.v_rd_en, 1'b0);
        check("rst/addr", bus.v_rd_addr, 0);
        check("rst/busy", bus.busy, 1'b0);
        check("rst/done", bus.done, 1'b0);
        check("rst/ctx", bus.ctx, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic weighted sum
        p_job = '{128, 64, 64};
        v_job = '{'{10, -20, 100, 0}, '{20, 40, -100, 4}, '{-40, 0, 0, 8}};
        set_job();
        bus.start = 1'b1;
        track("basic", 0, 1'b0);
        lit = '{0, 0, 25, 3};
        for (int d = 0; d < DIM; d++) begin
            cv = bus.ctx[d*V_W +: V_W];
            check($sformatf("basic/lit%0d", d), cv, lit[d]);
        end

        // Rounding half up toward +inf
        rand_job();
        p_job = '{128, 0, 0};
        v_job[0] = '{3, -3, 1, -1};
        set_job();
        bus.start = 1'b1;
        track("round", 0, 1'b0);
        lit = '{2, -1, 1, 0};
        for (int d = 0; d < DIM; d++) begin
            cv = bus.ctx[d*V_W +: V_W];
            check($sformatf("round/lit%0d", d), cv, lit[d]);
        end

        // Saturation both ways
        fill_job(255, 255, 255, 127);
        set_job();
        bus.start = 1'b1;
        track("sat_hi", 0, 1'b0);
        fill_job(255, 255, 255, -128);
        set_job();
        bus.start = 1'b1;
        track("sat_lo", 0, 1'b0);

        // Back-to-back: second start in the done cycle
        rand_job();
        set_job();
        bus.start = 1'b1;
        track("b2b_1", 0, 1'b1);
        track("b2b_2", 0, 1'b0);

        // Start while busy is ignored
        rand_job();
        set_job();
        bus.start = 1'b1;
        track("busy_ign", 2, 1'b0);
        repeat (3) begin
            @(posedge clk); #1;
            check("busy_ign/no_done", bus.done, 1'b0);
            check("busy_ign/idle", bus.busy, 1'b0);
        end

        // Reset mid-operation
        rand_job();
        set_job();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        check("mid_rst/en", bus.v_rd_en, 1'b0);
        check("mid_rst/busy", bus.busy, 1'b0);
        check("mid_rst/done", bus.done, 1'b0);
        check("mid_rst/ctx", bus.ctx, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
            check("mid_rst/no_done", bus.done, 1'b0);
            check("mid_rst/idle", bus.busy, 1'b0);
        end
        rand_job();
        set_job();
        bus.start = 1'b1;
        track("post_rst", 0, 1'b0);

        // Randomized jobs, with random chaining and ignored starts
        pending = 1'b0;
        for (int i = 0; i < 24; i++) begin
            if (!pending) begin
                rand_job();
                set_job();
                bus.start = 1'b1;
            end
            ch = (i < 23) && ($urandom_range(1) == 1);
            ex = ($urandom_range(2) == 0) ? int'($urandom_range(SEQ_LEN + 1, 1)) : 0;
            track($sformatf("rnd%0d", i), ex, ch);
            pending = ch;
        end

        @(posedge clk); #1;
        check("final/idle", bus.busy, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
